// File: rtl/knn_mem_pkg.sv
// Shared definitions for the SDRAM port arbiter slice.
//   - arb_state_e : arbiter FSM state encoding
//   - REQ_*       : requester IDs carried in the read tag FIFO
//   - DEFAULT_*   : default outstanding-read depth and burst cap
package knn_mem_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StGrant0 = 2'd1,
        StGrant1 = 2'd2
    } arb_state_e;

    localparam logic REQ_LOADER  = 1'b0;
    localparam logic REQ_MEMCTRL = 1'b1;

    localparam int unsigned DEFAULT_MAX_PEND   = 4;
    localparam int unsigned DEFAULT_BURST_HOLD = 8;

endpackage

// File: rtl/sdram_tag_fifo.sv
// In-order tag FIFO recording which requester issued each outstanding read.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset (empties the FIFO)
//   push, push_id: enqueue requester ID
//   pop          : dequeue head (ignored when empty)
//   full, empty  : occupancy flags
//   head         : ID of the oldest outstanding read
module sdram_tag_fifo
    import knn_mem_pkg::*;
#(
    parameter int unsigned MAX_PEND = DEFAULT_MAX_PEND
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    // Extra MSB distinguishes full from empty; MAX_PEND is a power of two.
    localparam int unsigned PTR_W = $clog2(MAX_PEND) + 1;

    logic [PTR_W-1:0]    wptr_q, rptr_q;
    logic [MAX_PEND-1:0] mem_q;
    logic                do_push, do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[PTR_W-1] != rptr_q[PTR_W-1]) &&
                     (wptr_q[PTR_W-2:0] == rptr_q[PTR_W-2:0]);
    assign do_pop  = pop & ~empty;
    // A pop frees a slot in the same cycle, so a push at full is legal then.
    assign do_push = push & (~full | do_pop);
    assign head    = mem_q[rptr_q[PTR_W-2:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            mem_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q[PTR_W-2:0]] <= push_id;
                wptr_q                   <= wptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM master port between the test-pattern loader (requester 0)
// and memory_control (requester 1). Round-robin grants with a burst cap;
// read responses are routed back in issue order via a tag FIFO.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   r0_* / r1_*              : requester slave ports (read/write/address/data,
//                              waitrequest, readdata, readdatavalid)
//   m_*                      : SDRAM master port
//   busy                     : grant active or reads outstanding
//   err                      : sticky, response seen with no outstanding read
module sdram_port_arbiter
    import knn_mem_pkg::*;
#(
    parameter int unsigned W          = 16,
    parameter int unsigned ADDR_W     = 25,
    parameter int unsigned MAX_PEND   = DEFAULT_MAX_PEND,
    parameter int unsigned BURST_HOLD = DEFAULT_BURST_HOLD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_read,
    input  logic              r0_write,
    input  logic [ADDR_W-1:0] r0_address,
    input  logic [W-1:0]      r0_writedata,
    output logic              r0_waitrequest,
    output logic [W-1:0]      r0_readdata,
    output logic              r0_readdatavalid,
    input  logic              r1_read,
    input  logic              r1_write,
    input  logic [ADDR_W-1:0] r1_address,
    input  logic [W-1:0]      r1_writedata,
    output logic              r1_waitrequest,
    output logic [W-1:0]      r1_readdata,
    output logic              r1_readdatavalid,
    output logic              m_read,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_address,
    output logic [W-1:0]      m_writedata,
    input  logic              m_waitrequest,
    input  logic [W-1:0]      m_readdata,
    input  logic              m_readdatavalid,
    output logic              busy,
    output logic              err
);

    localparam int unsigned       HOLD_W   = $clog2(BURST_HOLD + 1);
    localparam logic [HOLD_W:0]   HOLD_CAP = (HOLD_W + 1)'(BURST_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'(BURST_HOLD);

    arb_state_e        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [HOLD_W:0]   hold_next;
    logic              err_q;

    logic              gnt_active, gnt_id;
    logic              cur_read, cur_write, oth_req, read_block, accept, cur_wait;
    logic              req0, req1;
    logic              fifo_full, fifo_empty, fifo_head;

    assign req0 = r0_read | r0_write;
    assign req1 = r1_read | r1_write;

    // Datapath mux and handshake
    always_comb begin
        gnt_active = (state_q != StIdle);
        gnt_id     = (state_q == StGrant1);
        cur_read   = gnt_id ? r1_read  : r0_read;
        cur_write  = gnt_id ? r1_write : r0_write;
        oth_req    = gnt_id ? req0 : req1;
        // Only a pure read stalls on a full tag FIFO; read+write forwards the write.
        read_block = fifo_full & cur_read & ~cur_write;

        m_write     = gnt_active & cur_write;
        m_read      = gnt_active & cur_read & ~cur_write & ~read_block;
        m_address   = '0;
        m_writedata = '0;
        if (gnt_active) begin
            m_address   = gnt_id ? r1_address   : r0_address;
            m_writedata = gnt_id ? r1_writedata : r0_writedata;
        end

        accept         = (m_read | m_write) & ~m_waitrequest;
        cur_wait       = m_waitrequest | read_block;
        r0_waitrequest = (state_q == StGrant0) ? cur_wait : 1'b1;
        r1_waitrequest = (state_q == StGrant1) ? cur_wait : 1'b1;
    end

    // Next-state: arbitration and burst cap
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        hold_d       = hold_q;
        hold_next    = {1'b0, hold_q} + (HOLD_W + 1)'(1);

        case (state_q)
            StIdle: begin
                if (req0 && req1) begin
                    state_d = (last_grant_q == REQ_MEMCTRL) ? StGrant0 : StGrant1;
                end else if (req0) begin
                    state_d = StGrant0;
                end else if (req1) begin
                    state_d = StGrant1;
                end
            end
            StGrant0, StGrant1: begin
                if (!(cur_read || cur_write)) begin
                    state_d      = StIdle;
                    last_grant_d = gnt_id;
                    hold_d       = '0;
                end else if (accept) begin
                    if (hold_next >= HOLD_CAP) begin
                        if (oth_req) begin
                            // Hand over on the accept edge, no idle bubble.
                            state_d      = gnt_id ? StGrant0 : StGrant1;
                            last_grant_d = gnt_id;
                            hold_d       = '0;
                        end else begin
                            hold_d = HOLD_SAT;
                        end
                    end else begin
                        hold_d = hold_next[HOLD_W-1:0];
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            last_grant_q <= REQ_MEMCTRL;
            hold_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            hold_q       <= hold_d;
            if (m_readdatavalid && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    sdram_tag_fifo #(
        .MAX_PEND (MAX_PEND)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (accept & m_read),
        .push_id (gnt_id),
        .pop     (m_readdatavalid),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head)
    );

    // Response routing: zero-latency, steered by the oldest tag
    assign r0_readdata      = m_readdata;
    assign r1_readdata      = m_readdata;
    assign r0_readdatavalid = m_readdatavalid & ~fifo_empty & (fifo_head == REQ_LOADER);
    assign r1_readdatavalid = m_readdatavalid & ~fifo_empty & (fifo_head == REQ_MEMCTRL);

    assign busy = gnt_active | ~fifo_empty;
    assign err  = err_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
module tb_sdram_port_arbiter;

    localparam int unsigned W      = 16;
    localparam int unsigned ADDR_W = 25;

    logic              clk = 1'b0;
    logic              rst;
    logic              r0_read, r0_write, r1_read, r1_write;
    logic [ADDR_W-1:0] r0_address, r1_address;
    logic [W-1:0]      r0_writedata, r1_writedata;
    logic              r0_waitrequest, r1_waitrequest;
    logic [W-1:0]      r0_readdata, r1_readdata;
    logic              r0_readdatavalid, r1_readdatavalid;
    logic              m_read, m_write;
    logic [ADDR_W-1:0] m_address;
    logic [W-1:0]      m_writedata;
    logic              m_waitrequest;
    logic [W-1:0]      m_readdata;
    logic              m_readdatavalid;
    logic              busy, err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sdram_port_arbiter #(
        .W          (W),
        .ADDR_W     (ADDR_W),
        .MAX_PEND   (4),
        .BURST_HOLD (8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .r0_read          (r0_read),
        .r0_write         (r0_write),
        .r0_address       (r0_address),
        .r0_writedata     (r0_writedata),
        .r0_waitrequest   (r0_waitrequest),
        .r0_readdata      (r0_readdata),
        .r0_readdatavalid (r0_readdatavalid),
        .r1_read          (r1_read),
        .r1_write         (r1_write),
        .r1_address       (r1_address),
        .r1_writedata     (r1_writedata),
        .r1_waitrequest   (r1_waitrequest),
        .r1_readdata      (r1_readdata),
        .r1_readdatavalid (r1_readdatavalid),
        .m_read           (m_read),
        .m_write          (m_write),
        .m_address        (m_address),
        .m_writedata      (m_writedata),
        .m_waitrequest    (m_waitrequest),
        .m_readdata       (m_readdata),
        .m_readdatavalid  (m_readdatavalid),
        .busy             (busy),
        .err              (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the active edge; checks follow a settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b0;
        r0_read = 0; r0_write = 0; r0_address = '0; r0_writedata = '0;
        r1_read = 0; r1_write = 0; r1_address = '0; r1_writedata = '0;
        m_waitrequest = 0; m_readdata = '0; m_readdatavalid = 0;

        // Reset state
        #2;
        chk("rst_m_read", 32'(m_read), 0);
        chk("rst_m_write", 32'(m_write), 0);
        chk("rst_r0_wait", 32'(r0_waitrequest), 1);
        chk("rst_r1_wait", 32'(r1_waitrequest), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        tick(); tick();
        rst = 1'b1;
        settle();

        // Simultaneous requests after reset: last_grant=1, so R0 first
        r0_write = 1; r0_address = 'h30; r0_writedata = 'h1111;
        r1_write = 1; r1_address = 'h40; r1_writedata = 'h2222;
        settle();
        chk("both_idle_no_fwd", 32'(m_write), 0);
        tick();
        chk("both_g0_addr", 32'(m_address), 'h30);
        chk("both_g0_r0_wait", 32'(r0_waitrequest), 0);
        chk("both_g0_r1_wait", 32'(r1_waitrequest), 1);
        tick();
        r0_write = 0;
        tick();
        chk("both_idle_r0_wait", 32'(r0_waitrequest), 1);
        chk("both_idle_r1_wait", 32'(r1_waitrequest), 1);
        chk("both_idle_m_write", 32'(m_write), 0);
        r0_write = 1;
        tick();
        chk("both_g1_addr", 32'(m_address), 'h40);
        chk("both_g1_data", 32'(m_writedata), 'h2222);
        chk("both_g1_r1_wait", 32'(r1_waitrequest), 0);
        chk("both_g1_r0_wait", 32'(r0_waitrequest), 1);
        r0_write = 0; r1_write = 0;
        tick();
        chk("both_end_busy", 32'(busy), 0);

        // Single R0 write
        r0_write = 1; r0_address = 'h10; r0_writedata = 'h0005;
        settle();
        chk("w0_idle_m_write", 32'(m_write), 0);
        chk("w0_idle_r1_wait", 32'(r1_waitrequest), 1);
        tick();
        chk("w0_m_write", 32'(m_write), 1);
        chk("w0_m_addr", 32'(m_address), 'h10);
        chk("w0_m_data", 32'(m_writedata), 'h0005);
        chk("w0_r0_wait", 32'(r0_waitrequest), 0);
        chk("w0_r1_wait", 32'(r1_waitrequest), 1);
        chk("w0_busy", 32'(busy), 1);
        tick();
        r0_write = 0;
        tick();
        chk("w0_end_busy", 32'(busy), 0);

        // Burst cap: R1 writes, R0 waiting; handover after 8 accepts
        r1_write = 1; r1_address = 'h100; r1_writedata = 'hAAAA;
        tick();
        r0_write = 1; r0_address = 'h20; r0_writedata = 'h5555;
        for (int i = 0; i < 8; i++) begin
            settle();
            chk($sformatf("burst_r1_addr_%0d", i), 32'(m_address), 'h100);
            chk($sformatf("burst_r0_wait_%0d", i), 32'(r0_waitrequest), 1);
            tick();
        end
        chk("burst_sw_addr", 32'(m_address), 'h20);
        chk("burst_sw_r0_wait", 32'(r0_waitrequest), 0);
        chk("burst_sw_r1_wait", 32'(r1_waitrequest), 1);
        tick();
        r0_write = 0;
        tick();
        tick();
        chk("burst_resume_addr", 32'(m_address), 'h100);
        chk("burst_resume_r1_wait", 32'(r1_waitrequest), 0);
        tick(); tick(); tick(); tick();
        r1_write = 0;
        tick();
        chk("burst_end_busy", 32'(busy), 0);

        // Read back-pressure: FIFO depth 4
        r1_read = 1; r1_address = 'h200;
        tick();
        for (int i = 0; i < 4; i++) begin
            settle();
            chk($sformatf("rd_m_read_%0d", i), 32'(m_read), 1);
            tick();
        end
        chk("rd_full_m_read", 32'(m_read), 0);
        chk("rd_full_r1_wait", 32'(r1_waitrequest), 1);
        chk("rd_full_busy", 32'(busy), 1);
        tick();
        chk("rd_full_m_read_2", 32'(m_read), 0);
        m_readdatavalid = 1; m_readdata = 'hBEEF;
        settle();
        chk("rd_pop_r1_rdv", 32'(r1_readdatavalid), 1);
        chk("rd_pop_r0_rdv", 32'(r0_readdatavalid), 0);
        chk("rd_pop_r1_data", 32'(r1_readdata), 'hBEEF);
        chk("rd_pop_r0_data", 32'(r0_readdata), 'hBEEF);
        tick();
        m_readdatavalid = 0;
        settle();
        chk("rd_5th_m_read", 32'(m_read), 1);
        chk("rd_5th_r1_wait", 32'(r1_waitrequest), 0);
        tick();
        r1_read = 0;
        tick();
        chk("rd_idle_busy", 32'(busy), 1);
        for (int i = 0; i < 4; i++) begin
            m_readdatavalid = 1; m_readdata = W'('h100 + i);
            settle();
            chk($sformatf("rd_drain_r1_%0d", i), 32'(r1_readdatavalid), 1);
            chk($sformatf("rd_drain_r0_%0d", i), 32'(r0_readdatavalid), 0);
            tick();
        end
        m_readdatavalid = 0;
        settle();
        chk("rd_drain_busy", 32'(busy), 0);
        chk("rd_drain_err", 32'(err), 0);

        // Interleaved reads R0@A, R1@B, R0@C across grants
        r0_read = 1; r0_address = 'hA;
        tick(); tick();
        r0_read = 0;
        tick();
        r1_read = 1; r1_address = 'hB;
        tick(); tick();
        r1_read = 0;
        tick();
        r0_read = 1; r0_address = 'hC;
        tick();
        chk("il_c_addr", 32'(m_address), 'hC);
        tick();
        r0_read = 0;
        tick();
        m_readdatavalid = 1; m_readdata = 'hA0A0;
        settle();
        chk("il_a_r0_rdv", 32'(r0_readdatavalid), 1);
        chk("il_a_r1_rdv", 32'(r1_readdatavalid), 0);
        chk("il_a_data", 32'(r0_readdata), 'hA0A0);
        tick();
        m_readdatavalid = 0;
        settle();
        chk("il_gap_r0_rdv", 32'(r0_readdatavalid), 0);
        tick(); tick(); tick();
        m_readdatavalid = 1; m_readdata = 'hB0B0;
        settle();
        chk("il_b_r1_rdv", 32'(r1_readdatavalid), 1);
        chk("il_b_r0_rdv", 32'(r0_readdatavalid), 0);
        chk("il_b_data", 32'(r1_readdata), 'hB0B0);
        tick();
        m_readdatavalid = 0;
        tick();
        m_readdatavalid = 1; m_readdata = 'hC0C0;
        settle();
        chk("il_c_r0_rdv", 32'(r0_readdatavalid), 1);
        chk("il_c_r1_rdv", 32'(r1_readdatavalid), 0);
        chk("il_c_data", 32'(r0_readdata), 'hC0C0);
        tick();
        m_readdatavalid = 0;
        settle();
        chk("il_end_busy", 32'(busy), 0);
        chk("il_end_err", 32'(err), 0);

        // Spurious response sets sticky err
        m_readdatavalid = 1; m_readdata = 'hDEAD;
        settle();
        chk("sp_r0_rdv", 32'(r0_readdatavalid), 0);
        chk("sp_r1_rdv", 32'(r1_readdatavalid), 0);
        tick();
        m_readdatavalid = 0;
        settle();
        chk("sp_err", 32'(err), 1);
        tick();
        chk("sp_err_sticky", 32'(err), 1);

        // Reset mid-burst with two reads pending
        r0_read = 1; r0_address = 'h300;
        tick(); tick(); tick();
        chk("mr_busy", 32'(busy), 1);
        chk("mr_m_read", 32'(m_read), 1);
        rst = 1'b0;
        settle();
        chk("mr_rst_m_read", 32'(m_read), 0);
        chk("mr_rst_m_write", 32'(m_write), 0);
        chk("mr_rst_m_addr", 32'(m_address), 0);
        chk("mr_rst_r0_wait", 32'(r0_waitrequest), 1);
        chk("mr_rst_r1_wait", 32'(r1_waitrequest), 1);
        chk("mr_rst_busy", 32'(busy), 0);
        chk("mr_rst_err", 32'(err), 0);
        m_readdatavalid = 1;
        settle();
        chk("mr_rst_r0_rdv", 32'(r0_readdatavalid), 0);
        chk("mr_rst_r1_rdv", 32'(r1_readdatavalid), 0);
        m_readdatavalid = 0;
        r0_read = 0;
        tick();
        rst = 1'b1;
        settle();
        // Late response for a dropped tag
        m_readdatavalid = 1;
        settle();
        chk("late_r0_rdv", 32'(r0_readdatavalid), 0);
        tick();
        m_readdatavalid = 0;
        settle();
        chk("late_err", 32'(err), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single SDRAM master port between two requesters.
- Requester 0 is the test-pattern loader. Requester 1 is memory_control.
- Replaces the static write-path mux keyed on sdram_write_complete. Both requesters may issue interleaved reads and writes.
- Grants are round-robin with a burst cap. Pipelined read responses are routed back through an in-order tag FIFO.

Parameters:
- W, 16: data width.
- ADDR_W, 25: address width.
- MAX_PEND, 4: maximum outstanding reads; depth of the tag FIFO.
- BURST_HOLD, 8: maximum consecutive accepted commands per grant while the other requester is waiting.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- r0_read  in  1  requester 0 read request.
- r0_write  in  1  requester 0 write request.
- r0_address  in  ADDR_W  requester 0 address.
- r0_writedata  in  W  requester 0 write data.
- r0_waitrequest  out  1  requester 0 stall.
- r0_readdata  out  W  requester 0 read data.
- r0_readdatavalid  out  1  requester 0 read data valid.
- r1_read, r1_write, r1_address, r1_writedata, r1_waitrequest, r1_readdata, r1_readdatavalid: same widths, directions and meaning for requester 1.
- m_read  out  1  master read command.
- m_write  out  1  master write command.
- m_address  out  ADDR_W  master address.
- m_writedata  out  W  master write data.
- m_waitrequest  in  1  SDRAM stall.
- m_readdata  in  W  SDRAM read data.
- m_readdatavalid  in  1  SDRAM read data valid.
- busy  out  1  grant active or reads outstanding.
- err  out  1  sticky: readdatavalid received with no outstanding read.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, last_grant=1, hold count=0, tag FIFO emptied, err=0. Consequences: m_read=m_write=0, r*_readdatavalid=0, r*_waitrequest=1, busy=0. Reset mid-transaction drops all pending tags; responses arriving after reset set err.
- FSM states: IDLE, GRANT0, GRANT1.
  - IDLE: if exactly one requester asserts read|write, go to its GRANT state next cycle.
  - IDLE, both requesting: grant the one that is not last_grant.
  - Arbitration latency is 1 cycle; no command is forwarded while in IDLE.
- In GRANTx:
  - Forward rx_read/rx_write/rx_address/rx_writedata combinationally to m_*.
  - rx_waitrequest = m_waitrequest | read_block.
  - The other requester's waitrequest is held at 1.
  - Accept condition: (m_read|m_write) & !m_waitrequest.
  - Each accept increments the hold count.
- read_block is asserted when the tag FIFO is full and rx_read=1. While read_block is set, m_read is forced 0.
- A write is never blocked by the tag FIFO.
- rx_read and rx_write asserted together is an illegal input: the write is forwarded and the read is ignored (m_read=0).
- Leaving GRANTx:
  - If rx requests nothing in a cycle, go to IDLE, set last_grant=x, clear the hold count.
  - If hold count reaches BURST_HOLD while the other requester is requesting, move directly to the other GRANT state on that accept edge, with no IDLE bubble, and clear the hold count.
  - Otherwise, when hold count reaches BURST_HOLD, saturate it and keep the grant.
- Tag FIFO:
  - Push the granted ID on every accepted read.
  - Pop on m_readdatavalid.
  - Route the response: r{ID}_readdatavalid = m_readdatavalid & (head==ID), combinational, 0-cycle latency.
  - r0_readdata = r1_readdata = m_readdata at all times.
  - Push and pop in the same cycle are allowed at any fill level, including full (pop first) and empty (push then pop is illegal: a response cannot precede its command).
  - Wrap-around uses pointers of width clog2(MAX_PEND)+1.
  - m_readdatavalid with the FIFO empty: no routing, no pop, err<=1 (sticky until reset).
- Grants may switch with reads still outstanding; responses always return in issue order.
- busy = (state!=IDLE) | !fifo_empty.

Decomposition:
- Shared package knn_mem_pkg:
  - FSM state encoding.
  - Requester ID constants: REQ_LOADER=0, REQ_MEMCTRL=1.
  - Default MAX_PEND and BURST_HOLD.
- Sub-module sdram_tag_fifo: 1-bit-wide, MAX_PEND-deep FIFO with push, pop, full, empty and head outputs, and asynchronous active-low reset.

Test Plan:
- R0 writes addr 0x10 data 0x0005, no stall: GRANT0 one cycle after the request; m_write=1 with m_address=0x10 in that cycle; r1_waitrequest=1 throughout.
- Both request in the same cycle after reset (last_grant=1): R0 is granted first. Then R0 drops, both re-request, and R1 is granted.
- R1 holds 12 continuous writes while R0 requests: after 8 accepts the grant moves to GRANT1→GRANT0 on the same edge. R0's command is on m_* the next cycle, and R1 resumes after R0 drops.
- R1 issues 5 back-to-back reads, no readdatavalid: 4 are accepted, and the 5th sees r1_waitrequest=1 with m_read=0. One readdatavalid pops a tag and the 5th read is accepted in the same or next cycle.
- Interleaved reads R0@A, R1@B, R0@C, responses returning 3, 7, 9 cycles later: r0_readdatavalid, r1_readdatavalid, r0_readdatavalid pulse in that order with matching m_readdata.
- m_readdatavalid pulsed with no reads outstanding: err=1 and stays 1. Then assert rst=0 mid-burst with 2 reads pending: all m_* and r*_readdatavalid go to 0 immediately, r*_waitrequest=1, and busy=0.
